// File: rtl/mmu_frame_scheduler.sv
// Read-side sequencer for the SDRAM frame-buffer MMU: picks the displayed image,
// derives its read window and reloads the read FIFO only inside vertical blanking.
module mmu_frame_scheduler #(
    parameter logic [23:0] IMG_SPAN      = 24'd768000,
    parameter int unsigned MAX_IMG       = 21,
    parameter int unsigned LOAD_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic        iCLK_33,
    input  logic        iRST_N,
    input  logic        i_image_loaded,
    input  logic [7:0]  i_img_tot,
    input  logic        i_vsync_start,
    input  logic        i_next,
    input  logic        i_prev,
    input  logic        i_auto_en,
    input  logic [7:0]  i_auto_period,
    output logic [23:0] o_base_address,
    output logic [23:0] o_max_address,
    output logic        o_load_new,
    output logic        o_display_en,
    output logic [7:0]  o_img_idx,
    output logic        o_busy
);

    typedef enum logic [2:0] {StWaitImg, StDisplay, StPend, StLoad, StSettle} state_e;

    state_e      state_q;
    logic [7:0]  tgt_idx_q;
    logic [23:0] tgt_base_q;
    logic [23:0] last_base_q;
    logic [7:0]  auto_cnt_q;
    logic [7:0]  phase_q;

    logic [7:0]  eff_tot;
    logic [4:0]  eff_m1;
    logic [23:0] last_base_d;
    logic        at_last;
    logic        at_first;
    logic [7:0]  next_idx;
    logic [23:0] next_base;
    logic [7:0]  prev_idx;
    logic [23:0] prev_base;
    logic        auto_on;
    logic        auto_fire;

    always_comb begin
        eff_tot = (i_img_tot > 8'(MAX_IMG)) ? 8'(MAX_IMG) : i_img_tot;
        eff_m1  = eff_tot[4:0] - 5'd1;
        // Shift-add of the clamped count; at most five terms since eff_tot <= 21.
        last_base_d = '0;
        for (int b = 0; b < 5; b++) begin
            if (eff_m1[b]) last_base_d = last_base_d + (IMG_SPAN << b);
        end
        at_last   = (o_img_idx == eff_tot - 8'd1);
        at_first  = (o_img_idx == 8'd0);
        next_idx  = at_last ? 8'd0 : o_img_idx + 8'd1;
        next_base = at_last ? 24'd0 : o_base_address + IMG_SPAN;
        prev_idx  = at_first ? eff_tot - 8'd1 : o_img_idx - 8'd1;
        prev_base = at_first ? last_base_q : o_base_address - IMG_SPAN;
        auto_on   = i_auto_en && (i_auto_period != 8'd0);
        auto_fire = auto_on && i_vsync_start && (auto_cnt_q + 8'd1 == i_auto_period);
    end

    always_ff @(posedge iCLK_33 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q        <= StWaitImg;
            tgt_idx_q      <= '0;
            tgt_base_q     <= '0;
            last_base_q    <= '0;
            auto_cnt_q     <= '0;
            phase_q        <= '0;
            o_img_idx      <= '0;
            o_base_address <= '0;
            o_max_address  <= IMG_SPAN;
            o_load_new     <= 1'b0;
            o_display_en   <= 1'b0;
            o_busy         <= 1'b1;
        end else begin
            unique case (state_q)
                StWaitImg: begin
                    o_display_en <= 1'b0;
                    o_busy       <= 1'b1;
                    auto_cnt_q   <= '0;
                    last_base_q  <= last_base_d;
                    if (i_image_loaded && eff_tot != 8'd0) begin
                        tgt_idx_q  <= '0;
                        tgt_base_q <= '0;
                        state_q    <= StPend;
                    end
                end
                StDisplay: begin
                    last_base_q <= last_base_d;
                    if (!i_image_loaded || eff_tot == 8'd0) begin
                        o_display_en <= 1'b0;
                        o_busy       <= 1'b1;
                        auto_cnt_q   <= '0;
                        state_q      <= StWaitImg;
                    end else if (o_img_idx >= eff_tot) begin
                        tgt_idx_q  <= '0;
                        tgt_base_q <= '0;
                        o_busy     <= 1'b1;
                        auto_cnt_q <= '0;
                        state_q    <= StPend;
                    end else if (i_next || auto_fire) begin
                        tgt_idx_q  <= next_idx;
                        tgt_base_q <= next_base;
                        o_busy     <= 1'b1;
                        auto_cnt_q <= '0;
                        state_q    <= StPend;
                    end else if (i_prev) begin
                        tgt_idx_q  <= prev_idx;
                        tgt_base_q <= prev_base;
                        o_busy     <= 1'b1;
                        auto_cnt_q <= '0;
                        state_q    <= StPend;
                    end else if (!auto_on) begin
                        auto_cnt_q <= '0;
                    end else if (i_vsync_start) begin
                        auto_cnt_q <= auto_cnt_q + 8'd1;
                    end
                end
                StPend: begin
                    // Display enable holds its value until the blanking commit.
                    if (i_vsync_start) begin
                        o_img_idx      <= tgt_idx_q;
                        o_base_address <= tgt_base_q;
                        o_max_address  <= tgt_base_q + IMG_SPAN;
                        o_load_new     <= 1'b1;
                        o_display_en   <= 1'b0;
                        phase_q        <= '0;
                        state_q        <= StLoad;
                    end
                end
                StLoad: begin
                    if (phase_q == 8'(LOAD_CYCLES - 1)) begin
                        o_load_new <= 1'b0;
                        phase_q    <= '0;
                        state_q    <= StSettle;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                StSettle: begin
                    if (phase_q == 8'(SETTLE_CYCLES - 1)) begin
                        phase_q      <= '0;
                        o_display_en <= 1'b1;
                        o_busy       <= 1'b0;
                        state_q      <= StDisplay;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                default: state_q <= StWaitImg;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_frame_scheduler.sv
// Bench for mmu_frame_scheduler: a queue of expected read windows is filled as
// requests are issued and drained on each reload strobe.
module tb_mmu_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        image_loaded = 1'b0;
    logic [7:0]  img_tot = 8'd0;
    logic        vsync = 1'b0;
    logic        nxt = 1'b0;
    logic        prv = 1'b0;
    logic        auto_en = 1'b0;
    logic [7:0]  auto_period = 8'd0;
    logic [23:0] base_addr;
    logic [23:0] max_addr;
    logic        load_new;
    logic        display_en;
    logic [7:0]  img_idx;
    logic        busy;

    typedef struct {
        logic [7:0]  idx;
        logic [23:0] base;
        logic [23:0] maxa;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rises  = 0;
    int   m_idx  = 0;
    int   m_tot  = 0;
    logic prev_load = 1'b0;

    mmu_frame_scheduler dut (
        .iCLK_33        (clk),
        .iRST_N         (rst_n),
        .i_image_loaded (image_loaded),
        .i_img_tot      (img_tot),
        .i_vsync_start  (vsync),
        .i_next         (nxt),
        .i_prev         (prv),
        .i_auto_en      (auto_en),
        .i_auto_period  (auto_period),
        .o_base_address (base_addr),
        .o_max_address  (max_addr),
        .o_load_new     (load_new),
        .o_display_en   (display_en),
        .o_img_idx      (img_idx),
        .o_busy         (busy)
    );

    always #15 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard drain: every rising reload strobe must match the oldest expected window.
    always @(negedge clk) begin
        if (rst_n && load_new && !prev_load) begin
            rises  <= rises + 1;
            checks <= checks + 1;
            if (sb.size() == 0) begin
                errors <= errors + 1;
                $display("FAIL reload_unexpected: got idx=%0d base=%0d, required no reload",
                         img_idx, base_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (img_idx !== e.idx || base_addr !== e.base || max_addr !== e.maxa) begin
                    errors <= errors + 1;
                    $display("FAIL reload_window: got idx=%0d base=%0d max=%0d, required idx=%0d base=%0d max=%0d",
                             img_idx, base_addr, max_addr, e.idx, e.base, e.maxa);
                end
            end
        end
        prev_load <= load_new;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        int unsigned b;
        b      = idx * 768000;
        e.idx  = 8'(idx);
        e.base = 24'(b);
        e.maxa = 24'(b + 768000);
        sb.push_back(e);
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
    endtask

    task automatic wait_display(input string name);
        int n = 0;
        while (!(display_en === 1'b1 && busy === 1'b0) && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: got display_en=%b busy=%b, required 1/0 within 300 cycles",
                     name, display_en, busy);
        end
    endtask

    task automatic check_state(input string name);
        int unsigned b;
        b = m_idx * 768000;
        checks++;
        if (img_idx !== 8'(m_idx) || base_addr !== 24'(b)) begin
            errors++;
            $display("FAIL %s: got idx=%0d base=%0d, required idx=%0d base=%0d",
                     name, img_idx, base_addr, m_idx, b);
        end
    endtask

    // Issues next/prev from DISPLAY, commits on the following vsync, waits for DISPLAY.
    task automatic do_req(input string name, input bit nx, input bit pv);
        int r0 = rises;
        if (nx) m_idx = (m_idx + 1) % m_tot;
        else    m_idx = (m_idx + m_tot - 1) % m_tot;
        push_exp(m_idx);
        nxt = nx;
        prv = pv;
        tick(1);
        nxt = 1'b0;
        prv = 1'b0;
        tick(2);
        pulse_vsync();
        checks++;
        if (load_new !== 1'b1) begin
            errors++;
            $display("FAIL %s_load: got load_new=%b, required 1", name, load_new);
        end
        wait_display(name);
        check_state(name);
        checks++;
        if (rises - r0 !== 1) begin
            errors++;
            $display("FAIL %s_bursts: got %0d reloads, required 1", name, rises - r0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        image_loaded = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        m_idx = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (img_idx !== 8'd0 || base_addr !== 24'd0 || max_addr !== 24'd768000) begin
            errors++;
            $display("FAIL reset_addr: got idx=%0d base=%0d max=%0d, required 0/0/768000",
                     img_idx, base_addr, max_addr);
        end
        checks++;
        if (load_new !== 1'b0 || display_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got load=%b disp=%b busy=%b, required 0/0/1",
                     load_new, display_en, busy);
        end
    endtask

    task automatic test_boot();
        int cnt = 0;
        int n = 0;
        img_tot = 8'd3;
        m_tot = 3;
        image_loaded = 1'b1;
        tick(2);
        push_exp(0);
        pulse_vsync();
        checks++;
        if (load_new !== 1'b1) begin
            errors++;
            $display("FAIL boot_load_start: got load_new=%b, required 1", load_new);
        end
        while (load_new === 1'b1 && cnt < 10) begin
            cnt++;
            tick(1);
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL boot_load_len: got %0d cycles, required 4", cnt);
        end
        while (display_en !== 1'b1 && n < 200) begin
            n++;
            tick(1);
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL boot_settle_len: got %0d cycles, required 64", n);
        end
        checks++;
        if (busy !== 1'b0 || max_addr !== 24'd768000) begin
            errors++;
            $display("FAIL boot_display: got busy=%b max=%0d, required 0/768000", busy, max_addr);
        end
    endtask

    task automatic test_next_wrap();
        do_req("next_1", 1'b1, 1'b0);
        do_req("next_2", 1'b1, 1'b0);
        do_req("next_wrap", 1'b1, 1'b0);
    endtask

    task automatic test_prev();
        do_req("prev_wrap", 1'b0, 1'b1);
        checks++;
        if (max_addr !== 24'd2304000) begin
            errors++;
            $display("FAIL prev_wrap_max: got %0d, required 2304000", max_addr);
        end
        do_req("next_and_prev", 1'b1, 1'b1);
    endtask

    task automatic test_auto();
        int r0;
        auto_en = 1'b1;
        auto_period = 8'd5;
        tick(2);
        for (int i = 1; i <= 5; i++) begin
            pulse_vsync();
            tick(3);
            checks++;
            if (load_new !== 1'b0) begin
                errors++;
                $display("FAIL auto_early_%0d: got load_new=%b, required 0", i, load_new);
            end
        end
        m_idx = (m_idx + 1) % m_tot;
        push_exp(m_idx);
        pulse_vsync();
        auto_period = 8'd0;
        checks++;
        if (load_new !== 1'b1) begin
            errors++;
            $display("FAIL auto_reload: got load_new=%b, required 1", load_new);
        end
        wait_display("auto");
        check_state("auto_idx");
        r0 = rises;
        for (int i = 0; i < 20; i++) begin
            pulse_vsync();
            tick(3);
        end
        checks++;
        if (rises != r0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL auto_period0: got %0d reloads busy=%b, required 0 reloads busy=0",
                     rises - r0, busy);
        end
        auto_en = 1'b0;
    endtask

    task automatic test_drop_and_same_cycle();
        int r0 = rises;
        m_idx = (m_idx + 1) % m_tot;
        push_exp(m_idx);
        nxt = 1'b1;
        tick(1);
        nxt = 1'b0;
        tick(1);
        pulse_vsync();
        tick(10);
        nxt = 1'b1;
        tick(1);
        nxt = 1'b0;
        wait_display("drop");
        check_state("drop_idx");
        tick(5);
        checks++;
        if (rises - r0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_bursts: got %0d reloads busy=%b, required 1 busy=0",
                     rises - r0, busy);
        end
        nxt = 1'b1;
        vsync = 1'b1;
        tick(1);
        nxt = 1'b0;
        vsync = 1'b0;
        tick(3);
        checks++;
        if (load_new !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_pend: got load=%b busy=%b, required 0/1", load_new, busy);
        end
        m_idx = (m_idx + 1) % m_tot;
        push_exp(m_idx);
        pulse_vsync();
        checks++;
        if (load_new !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_commit: got load_new=%b, required 1", load_new);
        end
        wait_display("same_cycle");
        check_state("same_cycle_idx");
    endtask

    task automatic test_clamp_and_reset();
        do_reset();
        img_tot = 8'd30;
        m_tot = 21;
        image_loaded = 1'b1;
        tick(2);
        push_exp(0);
        pulse_vsync();
        wait_display("clamp_boot");
        m_idx = 20;
        push_exp(20);
        prv = 1'b1;
        tick(1);
        prv = 1'b0;
        tick(1);
        pulse_vsync();
        tick(1);
        checks++;
        if (load_new !== 1'b1 || img_idx !== 8'd20 || base_addr !== 24'd15360000) begin
            errors++;
            $display("FAIL clamp_prev: got load=%b idx=%0d base=%0d, required 1/20/15360000",
                     load_new, img_idx, base_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (load_new !== 1'b0 || display_en !== 1'b0 || img_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_load: got load=%b disp=%b idx=%0d, required 0/0/0",
                     load_new, display_en, img_idx);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_boot();
        test_next_wrap();
        test_prev();
        test_auto();
        test_drop_and_same_cycle();
        test_clamp_and_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
